irq_encoder8to3: RTL and testbench
==================================

# irq_encoder8to3

Sequential 8-to-3 request encoder for the RISC16bit datapath; the encoding counterpart of the 3-to-8 decoder. It latches up to eight request lines into a pending register and selects one by priority. The selected index is presented as a 3-bit code with a valid/ack handshake, and the served pending bit is cleared on acceptance. It sits between peripheral request lines and the control unit's vector/branch logic.

## Interface
- No parameters; width fixed at 8 requests / 3-bit code.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- E  in  1  enable; gates request capture and new selections
- req  in  8  request lines, sampled every cycle, bit i = source i
- ack  in  1  consumer accepts the presented code
- code  out  3  selected index, registered
- valid  out  1  code is valid, registered
- pending  out  8  current pending register
- ovf  out  1  one-cycle pulse: a request hit an already-pending bit

## Operation
- Reset (async, rst_n=0): pending=8'h00, code=3'd0, valid=0, ovf=0, state=IDLE, rr pointer=3'd0.
- Pending update each edge: pending <= (pending & ~clr) | (E ? req : 8'h00).
  - clr = one-hot(code) when valid && ack, else 0.
  - Set wins over clear on the same bit in the same cycle.
- ovf <= E && |(req & pending & ~clr); registered, high for exactly one cycle per offending edge.
- FSM, two states:
  - IDLE: if E && pending!=0, load code=selected index, valid=1, go PRESENT; else hold, valid=0.
  - PRESENT: code and valid held stable regardless of E, req or pending changes. On ack: valid=0, clear pending[code], go IDLE.
- ack while valid=0 is ignored: no clear, no state change.
- Fixed priority (default): highest set index wins (7 over 6 over … over 0).
- E=0: requests not captured; pending retained; IDLE issues no grant; a presented code still completes on ack.

## Timing
- req high at edge n: pending bit set after edge n. In IDLE, valid=1 after edge n+1, i.e. 2-cycle latency.
- Accept: valid && ack at edge m gives valid=0 after m. The next code, if pending, appears after edge m+1. There is a mandatory one-cycle bubble between grants.
- Max throughput: one grant per 2 cycles with ack tied high.
- Reset mid-PRESENT: valid drops immediately (asynchronous). All pending requests are lost.
- Outputs are glitch-free, all driven from flops.

## Configuration
- IRQ_ENCODER_RR_EN defined: round-robin priority.
  - 3-bit pointer `last` is updated to code on each accept.
  - Search order is last-1, last-2, … wrapping mod 8, with `last` itself lowest.
  - `last` resets to 0, so the first search order is 7,6,…,0, identical to fixed priority.
- Undefined: fixed priority, no pointer logic.

## Test plan
- Reset: assert rst_n=0 mid-PRESENT with pending=8'hFF -> valid=0, code=0, pending=0, ovf=0 immediately.
- Single request: E=1, req=8'h10 one cycle -> valid=1 with code=4 two cycles later. Ack -> pending=0, valid=0.
- Fixed priority: req=8'h85 once, ack held high -> codes 7, 2, 0 on alternating cycles, then valid=0 and pending=0.
- Simultaneous set/clear: code=3 presented; ack and req=8'h08 in the same cycle -> pending[3] stays 1, code=3 re-presented after the bubble, ovf pulses once.
- Enable gating: E=0, req=8'hFF -> pending unchanged, no valid. Raise E with pending=8'h02 -> code=1 next cycle.
- RR (IRQ_ENCODER_RR_EN): pending=8'h81 held by repeated req, ack each grant -> codes 7, 0, 7, 0 (fixed mode gives 7, 7, 7).

Source files
------------

// File: rtl/irq_encoder8to3.sv
// Sequential 8-to-3 request encoder with pending register and valid/ack handshake.
// Define IRQ_ENCODER_RR_EN for round-robin priority; the default is fixed highest-index priority.
module irq_encoder8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pending,
    output logic       ovf
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    logic [7:0] clr;
    logic [7:0] set_v;
    logic [2:0] sel;

`ifdef IRQ_ENCODER_RR_EN
    logic [2:0] last;
`endif

    always_comb begin
        clr = '0;
        if (state == PRESENT && ack)
            clr[code] = 1'b1;
        set_v = E ? req : '0;
    end

`ifdef IRQ_ENCODER_RR_EN
    // Walk from farthest (last itself) to nearest (last-1) so the nearest set bit wins.
    always_comb begin
        sel = '0;
        for (int unsigned k = 8; k >= 1; k--) begin
            if (pending[last - 3'(k)])
                sel = last - 3'(k);
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pending[i])
                sel = 3'(i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            code    <= '0;
            valid   <= 1'b0;
            ovf     <= 1'b0;
`ifdef IRQ_ENCODER_RR_EN
            last    <= '0;
`endif
        end else begin
            pending <= (pending & ~clr) | set_v;
            ovf     <= |(set_v & pending & ~clr);
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (E && (pending != '0)) begin
                        code  <= sel;
                        valid <= 1'b1;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
`ifdef IRQ_ENCODER_RR_EN
                        last  <= code;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_encoder8to3.sv
// Self-checking bench for irq_encoder8to3: per-cycle model comparison plus directed literal checks.
module tb_irq_encoder8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       E = 1'b0;
    logic [7:0] req = '0;
    logic       ack = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       ovf;

    int checks = 0;
    int passes = 0;

    irq_encoder8to3 dut (
        .clk(clk), .rst_n(rst_n), .E(E), .req(req), .ack(ack),
        .code(code), .valid(valid), .pending(pending), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: pending set as a bit vector, grant chosen by distance from last grant.
    logic [7:0] m_pend  = '0;
    logic [2:0] m_code  = '0;
    logic       m_valid = 1'b0;
    logic       m_ovf   = 1'b0;
    int         m_last  = 0;

    function automatic logic [2:0] pick(input logic [7:0] p, input int last);
        for (int d = 1; d <= 8; d++) begin
            int idx;
            idx = (last + 8 - d) % 8;
            if (p[idx]) return 3'(idx);
        end
        return 3'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = '0; m_code = '0; m_valid = 1'b0; m_ovf = 1'b0; m_last = 0;
        end else begin
            logic [7:0] clr_m;
            logic [7:0] nxt;
            clr_m = '0;
            if (m_valid && ack) clr_m = 8'(1 << m_code);
            nxt   = (m_pend & ~clr_m) | (E ? req : 8'h00);
            m_ovf = E && ((req & m_pend & ~clr_m) != 8'h00);
            if (!m_valid) begin
                if (E && m_pend != 8'h00) begin
                    m_code  = pick(m_pend, m_last);
                    m_valid = 1'b1;
                end
            end else if (ack) begin
                m_valid = 1'b0;
`ifdef IRQ_ENCODER_RR_EN
                m_last  = int'(m_code);
`endif
            end
            m_pend = nxt;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_valid", 8'(valid), 8'(m_valid));
            if (m_valid) chk("cyc_code", 8'(code), 8'(m_code));
            chk("cyc_pending", pending, m_pend);
            chk("cyc_ovf", 8'(ovf), 8'(m_ovf));
        end
    end

    task automatic step(input logic e, input logic [7:0] r, input logic a);
        E = e; req = r; ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int grants;
        logic [2:0] got [4];
        logic [2:0] exp_rr [4];

        do_reset();
        chk("rst_valid", 8'(valid), 8'h00);
        chk("rst_pending", pending, 8'h00);

        // Single request, two-cycle latency
        step(1'b1, 8'h10, 1'b0);
        chk("single_pend", pending, 8'h10);
        chk("single_nv", 8'(valid), 8'h00);
        step(1'b1, 8'h00, 1'b0);
        chk("single_valid", 8'(valid), 8'h01);
        chk("single_code", 8'(code), 8'h04);
        chk("model_code4", 8'(m_code), 8'h04);
        step(1'b1, 8'h00, 1'b1);
        chk("single_acc_v", 8'(valid), 8'h00);
        chk("single_acc_p", pending, 8'h00);

        // Priority with ack held high: 7, 2, 0
        do_reset();
        step(1'b1, 8'h85, 1'b1);
        chk("pri_pend", pending, 8'h85);
        step(1'b1, 8'h00, 1'b1);
        chk("pri_c7", 8'(code), 8'h07);
        step(1'b1, 8'h00, 1'b1);
        chk("pri_bubble", 8'(valid), 8'h00);
        chk("pri_p05", pending, 8'h05);
        step(1'b1, 8'h00, 1'b1);
        chk("pri_c2", 8'(code), 8'h02);
        step(1'b1, 8'h00, 1'b1);
        step(1'b1, 8'h00, 1'b1);
        chk("pri_c0", 8'(code), 8'h00);
        chk("pri_v0", 8'(valid), 8'h01);
        step(1'b1, 8'h00, 1'b1);
        chk("pri_end_v", 8'(valid), 8'h00);
        chk("pri_end_p", pending, 8'h00);

        // Set wins over clear on the accepted bit
        do_reset();
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("sc_code", 8'(code), 8'h03);
        step(1'b1, 8'h08, 1'b1);
        chk("sc_pend", pending, 8'h08);
        chk("sc_ovf0", 8'(ovf), 8'h00);
        step(1'b1, 8'h08, 1'b0);
        chk("sc_repres", 8'(valid), 8'h01);
        chk("sc_code3", 8'(code), 8'h03);
        chk("sc_ovf1", 8'(ovf), 8'h01);
        chk("model_ovf", 8'(m_ovf), 8'h01);
        step(1'b1, 8'h00, 1'b0);
        chk("sc_ovf_end", 8'(ovf), 8'h00);

        // Enable gating
        do_reset();
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        chk("en_pend", pending, 8'h02);
        chk("en_nv", 8'(valid), 8'h00);
        step(1'b0, 8'hFF, 1'b1);
        chk("en_pend2", pending, 8'h02);
        chk("en_nv2", 8'(valid), 8'h00);
        step(1'b1, 8'h00, 1'b0);
        chk("en_valid", 8'(valid), 8'h01);
        chk("en_code", 8'(code), 8'h01);

        // Repeated 0x81 requests: round-robin alternates, fixed sticks at 7
`ifdef IRQ_ENCODER_RR_EN
        exp_rr = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
        exp_rr = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
        do_reset();
        step(1'b1, 8'h81, 1'b0);
        grants = 0;
        for (int n = 0; n < 20 && grants < 4; n++) begin
            step(1'b1, 8'h81, 1'b1);
            if (valid) begin
                got[grants] = code;
                grants++;
            end
        end
        chk("rr_grants", 8'(grants), 8'h04);
        for (int g = 0; g < 4; g++)
            chk($sformatf("rr_code%0d", g), 8'(got[g]), 8'(exp_rr[g]));

        // Asynchronous reset while presenting with all bits pending
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        chk("mid_valid", 8'(valid), 8'h01);
        chk("mid_pend", pending, 8'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 8'(valid), 8'h00);
        chk("arst_code", 8'(code), 8'h00);
        chk("arst_pend", pending, 8'h00);
        chk("arst_ovf", 8'(ovf), 8'h00);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
